// File: rtl/ika2151_pkg.sv
// Shared widths, strobe positions and the 18->16 bit saturation used by the
// channel accumulator / serial DAC path.
package ika2151_pkg;

  localparam int OP_W       = 14;
  localparam int ACC_W      = 18;
  localparam int DAC_W      = 16;
  localparam int MANT_W     = 10;
  localparam int EXP_W      = 3;
  localparam int PAD_W      = 3;
  localparam int NOISE_SLOT = 31;
  localparam int CNT_W      = $clog2(NOISE_SLOT + 1);

  // Counter value right after the tick that presents bit 15 of each word.
  localparam logic [CNT_W-1:0] SH1_CNT = CNT_W'(16);
  localparam logic [CNT_W-1:0] SH2_CNT = CNT_W'(0);

  localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

  // Serial word, MSB..LSB; shifted out LSB first (pad, mantissa, exponent).
  typedef struct packed {
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic [PAD_W-1:0]  pad;
  } dac_word_t;

  function automatic logic signed [DAC_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) return SAT_MAX[DAC_W-1:0];
    if (a < SAT_MIN) return SAT_MIN[DAC_W-1:0];
    return a[DAC_W-1:0];
  endfunction

endpackage

// File: rtl/ika2151_acc_fpconv.sv
// Combinational converter from a saturated 16-bit sample to the DAC's
// 3-bit exponent / 10-bit mantissa floating-point word.
module ika2151_acc_fpconv
  import ika2151_pkg::*;
(
  input  logic signed [DAC_W-1:0] x,
  output logic [DAC_W-1:0]        word
);

  logic [EXP_W-1:0]         e;
  logic signed [DAC_W-1:0]  hi;
  logic signed [DAC_W-1:0]  shifted;
  dac_word_t                w;

  // Scan from the widest window down so the smallest fitting exponent wins.
  always_comb begin
    e  = EXP_W'(7);
    hi = '0;
    for (int i = 7; i >= 1; i--) begin
      hi = x >>> (8 + i);
      if (hi == '0 || hi == '1) e = EXP_W'(i);
    end
  end

  assign shifted = x >>> (e - 1);

  always_comb begin
    w.e   = e;
    w.m   = shifted[MANT_W-1:0];
    w.pad = '0;
  end

  assign word = w;

endmodule

// File: rtl/ika2151_acc.sv
// Per-sample left/right channel accumulator with noise-slot substitution and
// serial float-word DAC transmitter with latch strobes.
module ika2151_acc
  import ika2151_pkg::*;
(
  input  logic            i_EMUCLK,
  input  logic            i_MRST_n,
  input  logic            i_phi1_PCEN_n,
  input  logic            i_phi1_NCEN_n,
  input  logic            i_CYCLE_00,
  input  logic            i_CYCLE_31,
  input  logic            i_NE,
  input  logic            i_ACC_SNDADD,
  input  logic [1:0]      i_RL,
  input  logic [OP_W-1:0] i_OP_OUT,
  input  logic [OP_W-1:0] i_ACC_NOISE,
  output logic            o_SO,
  output logic            o_SH1,
  output logic            o_SH2
);

  logic                         tick;
  logic                         unused_pcen;
  logic signed [OP_W-1:0]       samp;
  logic signed [ACC_W-1:0]      add;
  logic [1:0][DAC_W-1:0]        dac_word;
  logic [2*DAC_W-1:0]           shreg_reg;
  logic [CNT_W-1:0]             cnt_reg;
  logic [CNT_W-1:0]             cnt_next;

  assign tick        = ~i_phi1_NCEN_n;
  assign unused_pcen = i_phi1_PCEN_n;

  assign samp = (i_CYCLE_31 & i_NE) ? signed'(i_ACC_NOISE) : signed'(i_OP_OUT);
  assign add  = i_ACC_SNDADD ? ACC_W'(samp) : '0;

  // Channel 0 = left (RL[0]), channel 1 = right (RL[1]).
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] add_ch;
    logic signed [DAC_W-1:0] sat_x;

    assign add_ch = i_RL[gi] ? add : '0;

    // Slot 0 restarts the sum with its own term so no slot is dropped.
    always_ff @(posedge i_EMUCLK) begin
      if (!i_MRST_n) begin
        acc_reg <= '0;
      end else if (tick) begin
        acc_reg <= i_CYCLE_00 ? add_ch : acc_reg + add_ch;
      end
    end

    assign sat_x = sat16(acc_reg);

    ika2151_acc_fpconv u_fpconv (
      .x    (sat_x),
      .word (dac_word[gi])
    );
  end

  assign cnt_next = i_CYCLE_00 ? '0 : cnt_reg + CNT_W'(1);

  // o_SO takes the pre-shift LSB, so the freshly loaded word appears one tick later.
  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      o_SO      <= 1'b0;
      o_SH1     <= 1'b0;
      o_SH2     <= 1'b0;
    end else if (tick) begin
      o_SO      <= shreg_reg[0];
      shreg_reg <= i_CYCLE_00 ? dac_word : (shreg_reg >> 1);
      cnt_reg   <= cnt_next;
      o_SH1     <= (cnt_next == SH1_CNT);
      o_SH2     <= (cnt_next == SH2_CNT);
    end
  end

endmodule
